// File: rtl/arp_rx_pkg.sv
// Shared constants, field offsets and FSM encoding for the ARP receiver.
// Used by arp_rx and, when ARP_RX_CRC_EN is defined, by arp_rx_crc32.
package arp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_ARP,
        ST_TAIL,
        ST_DROP
    } state_e;

    localparam logic [3:0]  NIB_PRE      = 4'hA;
    localparam logic [3:0]  NIB_SFD      = 4'hB;

    localparam logic [7:0]  BCAST_BYTE   = 8'hFF;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  HLEN_ETH     = 8'h06;
    localparam logic [7:0]  PLEN_IPV4    = 8'h04;
    localparam logic [15:0] OPER_REQUEST = 16'h0001;
    localparam logic [15:0] OPER_REPLY   = 16'h0002;

    // Byte offsets counted from the first byte after the SFD.
    localparam logic [5:0]  OFF_SRC      = 6'd6;
    localparam logic [5:0]  OFF_TYPE_HI  = 6'd12;
    localparam logic [5:0]  OFF_TYPE_LO  = 6'd13;
    localparam logic [5:0]  OFF_HTYPE_HI = 6'd14;
    localparam logic [5:0]  OFF_HTYPE_LO = 6'd15;
    localparam logic [5:0]  OFF_PTYPE_HI = 6'd16;
    localparam logic [5:0]  OFF_PTYPE_LO = 6'd17;
    localparam logic [5:0]  OFF_HLEN     = 6'd18;
    localparam logic [5:0]  OFF_PLEN     = 6'd19;
    localparam logic [5:0]  OFF_OPER_HI  = 6'd20;
    localparam logic [5:0]  OFF_OPER_LO  = 6'd21;
    localparam logic [5:0]  OFF_SHA      = 6'd22;
    localparam logic [5:0]  OFF_SPA      = 6'd28;
    localparam logic [5:0]  OFF_THA      = 6'd32;
    localparam logic [5:0]  OFF_TPA      = 6'd38;
    localparam logic [5:0]  OFF_ARP_LAST = 6'd41;

    localparam int          MIN_FRAME_BYTES = 64;
    localparam logic [5:0]  LAST_MIN_IDX    = 6'(MIN_FRAME_BYTES - 1);

    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;

    // Byte idx (0 = first on the wire) of a big-endian MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
        logic [47:0] s;
        s = mac << (8 * int'(idx));
        return s[47:40];
    endfunction

endpackage

// File: rtl/arp_rx_if.sv
// Receive-side bus of the ARP receiver: nibble input stream and decoded results.
interface arp_rx_if;
    logic        rx_dv;
    logic [3:0]  rxd;
    logic        arp_valid;
    logic [15:0] arp_oper;
    logic [47:0] sender_mac;
    logic [31:0] sender_ip;
    logic        ip_match;
    logic        frame_err;
    logic        busy;

    modport master (
        output rx_dv, rxd,
        input  arp_valid, arp_oper, sender_mac, sender_ip, ip_match, frame_err, busy
    );

    modport slave (
        input  rx_dv, rxd,
        output arp_valid, arp_oper, sender_mac, sender_ip, ip_match, frame_err, busy
    );
endinterface

// File: rtl/arp_rx_crc32.sv
// Byte-wide Ethernet CRC-32, bits taken LSB first; compiled only when
// ARP_RX_CRC_EN is defined.
`ifdef ARP_RX_CRC_EN
module arp_rx_crc32
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            crc_d = {crc_d[30:0], 1'b0} ^ ((crc_d[31] ^ data_i[i]) ? CRC_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         crc_q <= CRC_INIT;
        else if (init_i) crc_q <= CRC_INIT;
        else if (en_i)   crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule
`endif

// File: rtl/arp_rx.sv
// Nibble-stream Ethernet ARP receiver: validates header/ARP fields and reports
// sender MAC/IP. Defining ARP_RX_CRC_EN adds an FCS check.
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'hAC162D0B5AA2,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80090
) (
    input  logic    clk,
    input  logic    rst,
    arp_rx_if.slave bus
);
    state_e      state_q, state_d;
    logic [5:0]  byte_cnt_q;
    logic [3:0]  hi_nib_q;
    logic        nib_odd_q, len_ok_q, first_q;
    logic        dst_bc_q, dst_uc_q, dst_bc_d, dst_uc_d;
    logic [15:0] oper_s_q;
    logic [47:0] sha_s_q;
    logic [31:0] spa_s_q, tpa_s_q;
    logic        arp_valid_q, frame_err_q, ip_match_q;
    logic [15:0] arp_oper_q;
    logic [47:0] sender_mac_q;
    logic [31:0] sender_ip_q;
    logic [7:0]  byte_val;
    logic        in_frame, byte_done, field_ok, crc_ok;
    logic        sfd_seen, drop_err, end_good, end_err;

    assign byte_val  = {hi_nib_q, bus.rxd};
    assign in_frame  = (state_q == ST_HDR) || (state_q == ST_ARP) || (state_q == ST_TAIL);
    assign byte_done = bus.rx_dv && nib_odd_q && in_frame;

    // Per-byte field check; the destination stays acceptable while either
    // the broadcast or the station address still matches every byte so far.
    always_comb begin
        dst_bc_d = dst_bc_q && (byte_val == BCAST_BYTE);
        dst_uc_d = dst_uc_q && (byte_val == mac_byte(LOCAL_MAC, byte_cnt_q));
        field_ok = 1'b1;
        if (byte_cnt_q < OFF_SRC) begin
            field_ok = dst_bc_d || dst_uc_d;
        end else begin
            case (byte_cnt_q)
                OFF_TYPE_HI:  field_ok = (byte_val == ETH_TYPE_ARP[15:8]);
                OFF_TYPE_LO:  field_ok = (byte_val == ETH_TYPE_ARP[7:0]);
                OFF_HTYPE_HI: field_ok = (byte_val == HTYPE_ETH[15:8]);
                OFF_HTYPE_LO: field_ok = (byte_val == HTYPE_ETH[7:0]);
                OFF_PTYPE_HI: field_ok = (byte_val == PTYPE_IPV4[15:8]);
                OFF_PTYPE_LO: field_ok = (byte_val == PTYPE_IPV4[7:0]);
                OFF_HLEN:     field_ok = (byte_val == HLEN_ETH);
                OFF_PLEN:     field_ok = (byte_val == PLEN_IPV4);
                OFF_OPER_HI:  field_ok = (byte_val == OPER_REQUEST[15:8]);
                OFF_OPER_LO:  field_ok = (byte_val == OPER_REQUEST[7:0]) ||
                                         (byte_val == OPER_REPLY[7:0]);
                default:      field_ok = 1'b1;
            endcase
        end
    end

`ifdef ARP_RX_CRC_EN
    logic [31:0] crc;

    arp_rx_crc32 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init_i (sfd_seen),
        .en_i   (byte_done),
        .data_i (byte_val),
        .crc_o  (crc)
    );

    assign crc_ok = (crc == CRC_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sfd_seen = 1'b0;
        drop_err = 1'b0;
        end_good = 1'b0;
        end_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    state_d = (!first_q && bus.rxd == NIB_PRE) ? ST_PRE : ST_DROP;
                    // A frame already in flight at reset release is dropped silently.
                    drop_err = !first_q && (bus.rxd != NIB_PRE);
                end
            end
            ST_PRE: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                    end_err = 1'b1;
                end else if (bus.rxd == NIB_SFD) begin
                    state_d  = ST_HDR;
                    sfd_seen = 1'b1;
                end else if (bus.rxd != NIB_PRE) begin
                    state_d  = ST_DROP;
                    drop_err = 1'b1;
                end
            end
            ST_HDR, ST_ARP: begin
                if (!bus.rx_dv) begin
                    state_d = ST_IDLE;
                    end_err = 1'b1;
                end else if (byte_done) begin
                    if (!field_ok) begin
                        state_d  = ST_DROP;
                        drop_err = 1'b1;
                    end else if (state_q == ST_HDR && byte_cnt_q == OFF_TYPE_LO) begin
                        state_d = ST_ARP;
                    end else if (state_q == ST_ARP && byte_cnt_q == OFF_ARP_LAST) begin
                        state_d = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (!bus.rx_dv) begin
                    state_d  = ST_IDLE;
                    end_good = len_ok_q && !nib_odd_q && crc_ok;
                    end_err  = !(len_ok_q && !nib_odd_q && crc_ok);
                end
            end
            ST_DROP: begin
                if (!bus.rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q      <= 1'b1;
            byte_cnt_q   <= '0;
            hi_nib_q     <= '0;
            nib_odd_q    <= 1'b0;
            len_ok_q     <= 1'b0;
            dst_bc_q     <= 1'b1;
            dst_uc_q     <= 1'b1;
            oper_s_q     <= '0;
            sha_s_q      <= '0;
            spa_s_q      <= '0;
            tpa_s_q      <= '0;
            arp_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            arp_oper_q   <= '0;
            sender_mac_q <= '0;
            sender_ip_q  <= '0;
            ip_match_q   <= 1'b0;
        end else begin
            first_q     <= 1'b0;
            arp_valid_q <= end_good;
            frame_err_q <= end_err || drop_err;
            if (sfd_seen) begin
                byte_cnt_q <= '0;
                nib_odd_q  <= 1'b0;
                len_ok_q   <= 1'b0;
                dst_bc_q   <= 1'b1;
                dst_uc_q   <= 1'b1;
            end else if (bus.rx_dv && in_frame && !nib_odd_q) begin
                hi_nib_q  <= bus.rxd;
                nib_odd_q <= 1'b1;
            end else if (byte_done) begin
                nib_odd_q <= 1'b0;
                if (byte_cnt_q == LAST_MIN_IDX) len_ok_q   <= 1'b1;
                else                            byte_cnt_q <= byte_cnt_q + 6'd1;
                if (byte_cnt_q < OFF_SRC) begin
                    dst_bc_q <= dst_bc_d;
                    dst_uc_q <= dst_uc_d;
                end
                if (byte_cnt_q >= OFF_OPER_HI && byte_cnt_q <= OFF_OPER_LO)
                    oper_s_q <= {oper_s_q[7:0], byte_val};
                if (byte_cnt_q >= OFF_SHA && byte_cnt_q < OFF_SPA)
                    sha_s_q <= {sha_s_q[39:0], byte_val};
                if (byte_cnt_q >= OFF_SPA && byte_cnt_q < OFF_THA)
                    spa_s_q <= {spa_s_q[23:0], byte_val};
                if (byte_cnt_q >= OFF_TPA && byte_cnt_q <= OFF_ARP_LAST)
                    tpa_s_q <= {tpa_s_q[23:0], byte_val};
            end
            if (end_good) begin
                arp_oper_q   <= oper_s_q;
                sender_mac_q <= sha_s_q;
                sender_ip_q  <= spa_s_q;
                ip_match_q   <= (tpa_s_q == LOCAL_IP);
            end
        end
    end

    assign bus.arp_valid  = arp_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.arp_oper   = arp_oper_q;
    assign bus.sender_mac = sender_mac_q;
    assign bus.sender_ip  = sender_ip_q;
    assign bus.ip_match   = ip_match_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_arp_rx.sv
// Scoreboard bench for arp_rx: directed frames push expected events, a
// negedge monitor pops and compares whenever arp_valid or frame_err pulses.
module tb_arp_rx;
    typedef struct {
        bit          is_valid;
        logic [15:0] oper;
        logic [47:0] mac;
        logic [31:0] ip;
        logic        match;
    } exp_t;

    localparam logic [47:0] BCAST     = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] LOCAL_MAC = 48'hAC162D0B5AA2;
    localparam logic [47:0] SHA_A     = 48'h001122334455;
    localparam logic [31:0] SPA_A     = 32'hC0A800A6;
    localparam logic [31:0] TPA_ME    = 32'hC0A80090;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_drive_cyc = 0;
    int   err_cyc = -1;

    logic [7:0]  frm[$];
    exp_t        sb[$];
    logic [15:0] last_oper;
    logic [47:0] last_mac;
    logic [31:0] last_ip;
    logic        last_match;

    arp_rx_if bus ();

    arp_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_valid(input logic [15:0] oper, input logic [47:0] mac,
                              input logic [31:0] ip, input logic match);
        exp_t e;
        last_oper  = oper;
        last_mac   = mac;
        last_ip    = ip;
        last_match = match;
        e = '{1'b1, oper, mac, ip, match};
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{1'b0, last_oper, last_mac, last_ip, last_match};
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.arp_valid || bus.frame_err)) begin
            check("pulse_exclusive", 64'(bus.arp_valid & bus.frame_err), 64'(0));
            if (bus.frame_err) err_cyc = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse at cycle %0d",
                         bus.arp_valid, bus.frame_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind_valid", 64'(bus.arp_valid), 64'(e.is_valid));
                check("arp_oper", 64'(bus.arp_oper), 64'(e.oper));
                check("sender_mac", 64'(bus.sender_mac), 64'(e.mac));
                check("sender_ip", 64'(bus.sender_ip), 64'(e.ip));
                check("ip_match", 64'(bus.ip_match), 64'(e.match));
            end
        end
    end

    // Reflected CRC-32 over frm[0..n-1]; returns the FCS value to transmit.
    function automatic logic [31:0] eth_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_field(input logic [47:0] v, input int nbytes);
        logic [47:0] s;
        s = v << (8 * (6 - nbytes));
        for (int i = 0; i < nbytes; i++) begin
            frm.push_back(s[47:40]);
            s = s << 8;
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype,
                               input logic [15:0] oper, input logic [47:0] sha,
                               input logic [31:0] spa, input logic [31:0] tpa);
        logic [31:0] fcs;
        frm.delete();
        push_field(dst, 6);
        push_field(48'h020000000001, 6);
        push_field({32'h0, etype}, 2);
        push_field(48'h0001, 2);
        push_field(48'h0800, 2);
        push_field(48'h06, 1);
        push_field(48'h04, 1);
        push_field({32'h0, oper}, 2);
        push_field(sha, 6);
        push_field({16'h0, spa}, 4);
        push_field(48'h0, 6);
        push_field({16'h0, tpa}, 4);
        while (frm.size() < 60) frm.push_back(8'h00);
        fcs = eth_fcs(60);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic drive_nib(input logic [3:0] n);
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b1;
        bus.rxd   = n;
        last_drive_cyc = cyc;
    endtask

    task automatic send_pre();
        repeat (15) drive_nib(4'hA);
        drive_nib(4'hB);
    endtask

    task automatic send_bytes(input int lo, input int hi);
        logic [7:0] b;
        for (int i = lo; i <= hi; i++) begin
            b = frm[i];
            drive_nib(b[7:4]);
            drive_nib(b[3:0]);
        end
    endtask

    task automatic end_frame();
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b0;
        bus.rxd   = 4'h0;
        repeat (6) @(posedge clk);
    endtask

    task automatic full_frame();
        send_pre();
        send_bytes(0, 63);
        end_frame();
    endtask

    initial begin
        int mark;
        rst        = 1'b1;
        bus.rx_dv  = 1'b0;
        bus.rxd    = 4'h0;
        last_oper  = '0;
        last_mac   = '0;
        last_ip    = '0;
        last_match = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arp_valid", 64'(bus.arp_valid), 64'(0));
        check("rst_frame_err", 64'(bus.frame_err), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_arp_oper", 64'(bus.arp_oper), 64'(0));
        check("rst_sender_mac", 64'(bus.sender_mac), 64'(0));
        check("rst_sender_ip", 64'(bus.sender_ip), 64'(0));
        check("rst_ip_match", 64'(bus.ip_match), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Broadcast request addressed to this station.
        build_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, TPA_ME);
        push_valid(16'h0001, SHA_A, SPA_A, 1'b1);
        full_frame();

        // Same request for another host.
        build_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, 32'hC0A8000A);
        push_valid(16'h0001, SHA_A, SPA_A, 1'b0);
        full_frame();

        // Unicast reply to LOCAL_MAC.
        build_frame(LOCAL_MAC, 16'h0806, 16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80001, TPA_ME);
        push_valid(16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A80001, 1'b1);
        full_frame();

        // IPv4 ethertype: rejected on byte 13, prior outputs hold.
        build_frame(BCAST, 16'h0800, 16'h0001, SHA_A, SPA_A, TPA_ME);
        push_err();
        err_cyc = -1;
        send_pre();
        send_bytes(0, 13);
        mark = last_drive_cyc;
        send_bytes(14, 63);
        end_frame();
        check("etype_err_cycle", 64'(err_cyc), 64'(mark + 1));

        // Unicast to a foreign MAC.
        build_frame(48'h020000000099, 16'h0806, 16'h0001, SHA_A, SPA_A, TPA_ME);
        push_err();
        full_frame();

        // OPER = 3.
        build_frame(BCAST, 16'h0806, 16'h0003, SHA_A, SPA_A, TPA_ME);
        push_err();
        full_frame();

        // rx_dv drops after byte 30; busy falls one cycle later.
        build_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, TPA_ME);
        push_err();
        send_pre();
        send_bytes(0, 30);
        @(posedge clk);
        #1;
        bus.rx_dv = 1'b0;
        @(negedge clk);
        check("busy_before_fall_seen", 64'(bus.busy), 64'(1));
        @(negedge clk);
        check("busy_after_fall", 64'(bus.busy), 64'(0));
        repeat (4) @(posedge clk);

        // 40-byte frame.
        push_err();
        send_pre();
        send_bytes(0, 39);
        end_frame();

        // 63 bytes: reaches TAIL but one short of the minimum length.
        push_err();
        send_pre();
        send_bytes(0, 62);
        end_frame();

        // 64 bytes plus a stray nibble.
        push_err();
        send_pre();
        send_bytes(0, 63);
        drive_nib(4'h0);
        end_frame();

        // Garbage nibble from idle.
        push_err();
        drive_nib(4'h5);
        drive_nib(4'h5);
        end_frame();

        // One FCS bit flipped.
        build_frame(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A80077, TPA_ME);
        frm[61] = frm[61] ^ 8'h10;
`ifdef ARP_RX_CRC_EN
        push_err();
`else
        push_valid(16'h0001, SHA_A, 32'hC0A80077, 1'b1);
`endif
        full_frame();

        // Reset mid-ARP, released while the frame is still on the wire.
        build_frame(BCAST, 16'h0806, 16'h0002, 48'h665544332211, 32'hC0A80055, TPA_ME);
        send_pre();
        send_bytes(0, 25);
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_oper  = '0;
        last_mac   = '0;
        last_ip    = '0;
        last_match = 1'b0;
        @(negedge clk);
        check("midrst_arp_oper", 64'(bus.arp_oper), 64'(0));
        check("midrst_sender_mac", 64'(bus.sender_mac), 64'(0));
        check("midrst_sender_ip", 64'(bus.sender_ip), 64'(0));
        check("midrst_ip_match", 64'(bus.ip_match), 64'(0));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_bytes(26, 27);
        @(negedge clk);
        check("post_rst_drop_busy", 64'(bus.busy), 64'(1));
        send_bytes(28, 63);
        end_frame();
        check("post_rst_outputs_held_zero", 64'(bus.sender_ip), 64'(0));

        // Next good frame is accepted normally.
        build_frame(BCAST, 16'h0806, 16'h0001, SHA_A, SPA_A, TPA_ME);
        push_valid(16'h0001, SHA_A, SPA_A, 1'b1);
        full_frame();

        repeat (20) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arp_rx.md
ARP_RX -- requirements
Module: arp_rx

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'hAC162D0B5AA2, the station MAC accepted as destination besides broadcast.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A80090 (192.168.0.144), the IP compared against ARP target IP.
REQ-003 SHALL have clk  input  1  the single clock; rx data sampled on its rising edge, one nibble per cycle.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have rx_dv  input  1  receive data valid, high for the whole frame including preamble.
REQ-006 SHALL have rxd  input  4  receive nibble; high nibble of each byte arrives first.
REQ-007 SHALL have arp_valid  output  1  one-cycle pulse: a good ARP frame completed.
REQ-008 SHALL have arp_oper  output  16  OPER field of the last good frame (1 request, 2 reply).
REQ-009 SHALL have sender_mac  output  48  SHA field of the last good frame.
REQ-010 SHALL have sender_ip  output  32  SPA field of the last good frame.
REQ-011 SHALL have ip_match  output  1  last good frame's TPA equals LOCAL_IP.
REQ-012 SHALL have frame_err  output  1  one-cycle pulse: frame aborted or rejected.
REQ-013 SHALL have busy  output  1  high while FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PRE, HDR, ARP, TAIL, DROP.
REQ-015 IDLE->PRE on rx_dv=1 with rxd=4'hA; rx_dv=1 with any other nibble -> DROP.
REQ-016 PRE SHALL stay on nibble 4'hA, go to HDR on 4'hB (SFD end), go to DROP on any other nibble.
REQ-017 Bytes SHALL be assembled from nibble pairs, {first,second}; a 6-bit byte counter starts at 0 on first byte after SFD, saturates at 63.
REQ-018 HDR (bytes 0-13): dest MAC must equal 48'hFFFFFFFFFFFF or LOCAL_MAC; ethertype (bytes 12-13) must equal 16'h0806.
REQ-019 ARP (bytes 14-41): HTYPE 16'h0001, PTYPE 16'h0800, HLEN 8'h06, PLEN 8'h04, OPER 1 or 2; SHA bytes 22-27, SPA 28-31, TPA 38-41 captured into shadow registers.
REQ-020 Any field mismatch SHALL move to DROP at the byte where it is detected.
REQ-021 TAIL SHALL consume padding and FCS until rx_dv falls.
REQ-022 On rx_dv fall in TAIL with byte count >=64 and even nibble count: shadow copied to outputs and arp_valid pulsed the following cycle; FSM -> IDLE.
REQ-023 Byte count <64, odd nibble count, or rx_dv fall in PRE/HDR/ARP SHALL pulse frame_err next cycle, outputs unchanged, -> IDLE.
REQ-024 DROP SHALL pulse frame_err once on entry and wait for rx_dv=0, then -> IDLE.
REQ-025 arp_valid and frame_err SHALL never be high in the same cycle.
REQ-026 Capture outputs SHALL hold their value between good frames.

Reset
REQ-027 rst SHALL force IDLE, clear counters and shadow registers, all outputs 0.
REQ-028 If rx_dv=1 on the first cycle after rst release, FSM SHALL enter DROP (no mid-frame resync), without frame_err.

Configuration
REQ-029 With ARP_RX_CRC_EN defined: CRC-32 (poly 04C11DB7, init FFFFFFFF, LSB-first per assembled byte) over all bytes after SFD; residue must equal 32'hC704DD7B at rx_dv fall, else frame_err instead of arp_valid.
REQ-030 Without ARP_RX_CRC_EN: FCS bytes counted but not checked; no CRC logic instantiated.

Structure
REQ-031 Package arp_pkg SHALL hold FSM state encoding, ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4, HLEN/PLEN constants, field byte offsets, MIN_FRAME_BYTES=64, CRC residue.
REQ-032 CRC SHALL be sub-module arp_rx_crc32 (byte-wide, init/enable inputs), instantiated only under ARP_RX_CRC_EN.

Verification
REQ-033 Broadcast request, SPA 192.168.0.166, TPA 192.168.0.144, SHA 00:11:22:33:44:55, 60B+FCS -> arp_valid, arp_oper=1, sender_ip=C0A800A6, ip_match=1.
REQ-034 Same frame with TPA 192.168.0.10 -> arp_valid, ip_match=0.
REQ-035 Ethertype 0x0800 -> frame_err at byte 13, no arp_valid, outputs hold prior values.
REQ-036 rx_dv dropped after byte 30 -> frame_err, busy low next cycle; 40-byte frame -> frame_err.
REQ-037 rst asserted mid-ARP, released with rx_dv=1 -> outputs 0, DROP, no pulses until next good frame.
REQ-038 ARP_RX_CRC_EN defined, one FCS bit flipped -> frame_err, no arp_valid; macro undefined -> arp_valid.
